mem_req_queue: RTL and testbench
================================

# mem_req_queue

Request buffer between the pipeline memory stage and `mem_system`. It accepts load/store requests over a valid/ready handshake and queues them in a small FIFO. It issues one request at a time to `mem_system`, holding `Addr`/`DataIn`/`Rd`/`Wr` stable until `Done`. Each completion is returned through a registered response port, so the pipeline never has to hold operands stable across a multi-cycle cache miss.

## Interface
Parameters:
- `DEPTH`, default 2: request FIFO entries. Power of two, ≥2.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  1  upstream request present
- `req_ready`  out  1  FIFO can accept (not full)
- `req_wr`  in  1  1 = store, 0 = load
- `req_addr`  in  16  byte address
- `req_data`  in  16  store data
- `rsp_valid`  out  1  response register holds a completion
- `rsp_ready`  in  1  downstream consumes response
- `rsp_data`  out  16  load data (0 for stores)
- `rsp_hit`  out  1  `CacheHit` sampled at `Done`
- `rsp_err`  out  1  error for this request
- `mem_addr`  out  16  to `mem_system.Addr`
- `mem_data_in`  out  16  to `mem_system.DataIn`
- `mem_rd`  out  1  to `mem_system.Rd`
- `mem_wr`  out  1  to `mem_system.Wr`
- `mem_data_out`  in  16  from `mem_system.DataOut`
- `mem_done`  in  1  from `mem_system.Done`
- `mem_hit`  in  1  from `mem_system.CacheHit`
- `mem_err`  in  1  from `mem_system.err`

Clock is `clk`; reset is `rst`, asynchronous and active-high.

## Operation
- **Enqueue:** a request is accepted when `req_valid & req_ready` at a clock edge.
- **FSM states:**
  - IDLE: nothing in flight.
  - BUSY: request in flight to `mem_system`.
  - WAITRSP: completion captured, response register still occupied.
- **IDLE → BUSY:** taken when the FIFO is non-empty and the response register is empty, or is being drained this cycle. On entry:
  - FIFO head is popped into an issue register.
  - `mem_addr`, `mem_data_in`, `mem_wr`/`mem_rd` are driven from that register.
- **BUSY:** `mem_rd` or `mem_wr` (exactly one) is held high and address/data are held constant every cycle until `mem_done` is sampled high. Both strobes are low in every other state.
- **On `mem_done`:** capture into the response register:
  - `rsp_data` = `mem_data_out` for loads, 0 for stores.
  - `rsp_hit` = `mem_hit`.
  - `rsp_err` = `mem_err`.
  - Then go to IDLE (or WAITRSP if the previous response is still undrained; this cannot occur given the issue rule, so reaching WAITRSP sets `rsp_err`).
- **Ordering:** responses are returned in request order. At most one request is in flight.
- **Same-cycle push and pop** on a full FIFO is allowed: `req_ready` reflects post-pop space only when the pop is decided combinationally from state. Simpler rule, adopted here: `req_ready = ~full`, with no bypass.
- **Pointers:** FIFO pointers are `$clog2(DEPTH)+1` bits and wrap modulo 2·DEPTH. Full/empty is decided by MSB comparison.
- **Response register:** cleared when `rsp_valid & rsp_ready`. A capture and a clear in the same cycle results in the new data being held.

## Timing
- **Reset values:**
  - FSM IDLE, FIFO empty.
  - `req_ready`=1.
  - `rsp_valid`=0, `rsp_data`=0, `rsp_hit`=0, `rsp_err`=0.
  - `mem_rd`=0, `mem_wr`=0, `mem_addr`=0, `mem_data_in`=0.
- **Minimum latency:** `req_valid` at edge N, first `mem_rd`/`mem_wr` in cycle N+1. `mem_done` in cycle M gives `rsp_valid` high in cycle M+1.
- **Back-to-back requests:** the next request issues no earlier than the cycle after `rsp_valid` rises, provided `rsp_ready` is high then. Strobes are guaranteed low for at least one cycle between requests.
- **Reset during BUSY:** strobes drop immediately (asynchronously). The queued and in-flight requests are discarded and no response is produced.

## Configuration
- `MEMQ_ALIGN_CHK_EN` defined:
  - A request with `req_addr[0]`=1 is still enqueued but never issued to `mem_system`.
  - When it reaches the head and is selected, it completes in one cycle with `rsp_err`=1, `rsp_data`=0, `rsp_hit`=0.
- `MEMQ_ALIGN_CHK_EN` undefined: all addresses are issued unchanged.

## Structure
- **Package `mem_req_pkg`:**
  - `typedef struct packed {logic wr; logic [15:0] addr; logic [15:0] data;} mem_req_t`.
  - FSM state enum `memq_state_t` {IDLE, BUSY, WAITRSP}.
  - Constant `MEMQ_ADDR_W` = 16.
- **Sub-module `mem_req_fifo`:** parameterized synchronous FIFO of `mem_req_t` with push/pop/full/empty and async active-high reset.

## Test plan
- **Single load:** store 0x1234 to 0x0040, then load 0x0040 with a stub `mem_system` asserting `mem_done` 4 cycles after issue → strobes held exactly until done, then `rsp_data`=0x1234, `rsp_hit` as stubbed, `rsp_err`=0.
- **Back-pressure:** hold `rsp_ready`=0 while 3 requests are offered with DEPTH=2 → `req_ready` drops after 2 queued and no second issue occurs until the response is consumed.
- **Ordering:** loads to 0x0010, 0x0020, 0x0030 with differing stub latencies (1, 20, 4 cycles) → responses in request order with matching data.
- **Stability:** random stall lengths 1–30 cycles → `mem_addr`/`mem_data_in`/strobes constant across every BUSY period, and strobes low for ≥1 cycle between requests.
- **Reset during BUSY:** `rst` pulsed during BUSY → strobes low the same cycle, `rsp_valid`=0, FIFO empty, `req_ready`=1.
- **Misaligned access:** with `MEMQ_ALIGN_CHK_EN`, load 0x0041 → no strobe, `rsp_err`=1 one cycle after selection. Without the macro, the same load is issued to `mem_system`.

Source files
------------

// File: rtl/mem_req_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mem_req_pkg
// Brief    : Request record, FSM state encoding and widths shared by the
//            memory request queue and its FIFO.
// Revision : 1.0 - initial release
// ============================================================================
package mem_req_pkg;

    localparam int MEMQ_ADDR_W = 16;
    localparam int MEMQ_DATA_W = 16;

    typedef struct packed {
        logic                   wr;
        logic [MEMQ_ADDR_W-1:0] addr;
        logic [MEMQ_DATA_W-1:0] data;
    } mem_req_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        WAITRSP = 2'd2
    } memq_state_t;

    // Halfword accesses must be even-addressed.
    function automatic logic memq_is_misaligned(input mem_req_t req);
        return req.addr[0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_req_fifo.sv
`default_nettype none
// ============================================================================
// Module   : mem_req_fifo
// Brief    : Synchronous FIFO of mem_req_t entries with push/pop/full/empty.
//            Pointers carry one extra wrap bit so full and empty differ only
//            in the MSB.
// Revision : 1.0 - initial release
// ============================================================================
module mem_req_fifo
    import mem_req_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     i_push,
    input  mem_req_t i_push_data,
    input  logic     i_pop,
    output mem_req_t o_head,
    output logic     o_full,
    output logic     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    mem_req_t      r_mem [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    assign o_head = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_req_queue.sv
`default_nettype none
// ============================================================================
// Module   : mem_req_queue
// Brief    : Queues pipeline load/store requests, issues them one at a time to
//            mem_system and returns each completion through a response register.
// Config   : MEMQ_ALIGN_CHK_EN - odd addresses complete locally with rsp_err.
// Revision : 1.0 - initial release
// ============================================================================
module mem_req_queue
    import mem_req_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    // request side
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_wr,
    input  logic [MEMQ_ADDR_W-1:0] req_addr,
    input  logic [MEMQ_DATA_W-1:0] req_data,
    // response side
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [MEMQ_DATA_W-1:0] rsp_data,
    output logic                   rsp_hit,
    output logic                   rsp_err,
    // mem_system side
    output logic [MEMQ_ADDR_W-1:0] mem_addr,
    output logic [MEMQ_DATA_W-1:0] mem_data_in,
    output logic                   mem_rd,
    output logic                   mem_wr,
    input  logic [MEMQ_DATA_W-1:0] mem_data_out,
    input  logic                   mem_done,
    input  logic                   mem_hit,
    input  logic                   mem_err
);

    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_BUSY    = BUSY;
    localparam logic [1:0] ST_WAITRSP = WAITRSP;

    logic [1:0]             r_state;
    mem_req_t               r_issue;
    logic                   r_rsp_valid;
    logic [MEMQ_DATA_W-1:0] r_rsp_data;
    logic                   r_rsp_hit;
    logic                   r_rsp_err;

    mem_req_t w_push_req;
    mem_req_t w_head;
    logic     w_full;
    logic     w_empty;
    logic     w_push;
    logic     w_start;
    logic     w_misaligned;
    logic     w_done;
    logic     w_rsp_drain;
    logic     w_rsp_free;
    logic     w_rsp_stuck;

    assign w_push_req = '{wr: req_wr, addr: req_addr, data: req_data};
    assign w_push     = req_valid & ~w_full;
    assign req_ready  = ~w_full;

    mem_req_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_push_data(w_push_req),
        .i_pop      (w_start),
        .o_head     (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    assign w_rsp_drain = r_rsp_valid & rsp_ready;
    assign w_rsp_free  = ~r_rsp_valid | rsp_ready;
    assign w_rsp_stuck = r_rsp_valid & ~rsp_ready;

    // Issue only when the completion will have somewhere to land.
    assign w_start = (r_state == ST_IDLE) & ~w_empty & w_rsp_free;
    assign w_done  = (r_state == ST_BUSY) & mem_done;

`ifdef MEMQ_ALIGN_CHK_EN
    assign w_misaligned = memq_is_misaligned(w_head);
`else
    assign w_misaligned = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_issue <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start && !w_misaligned) begin
                        r_issue <= w_head;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (mem_done) begin
                        r_state <= w_rsp_stuck ? ST_WAITRSP : ST_IDLE;
                    end
                end
                ST_WAITRSP: begin
                    if (w_rsp_drain) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // A capture takes priority over a drain so the new completion is kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_hit   <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else if (w_done) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= r_issue.wr ? '0 : mem_data_out;
            r_rsp_hit   <= mem_hit;
            r_rsp_err   <= mem_err | w_rsp_stuck;
        end else if (w_start && w_misaligned) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= '0;
            r_rsp_hit   <= 1'b0;
            r_rsp_err   <= 1'b1;
        end else if (w_rsp_drain) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_hit   <= 1'b0;
            r_rsp_err   <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_hit   = r_rsp_hit;
    assign rsp_err   = r_rsp_err;

    // Strobes decode straight from state so an async reset drops them at once.
    assign mem_rd      = (r_state == ST_BUSY) & ~r_issue.wr;
    assign mem_wr      = (r_state == ST_BUSY) &  r_issue.wr;
    assign mem_addr    = r_issue.addr;
    assign mem_data_in = r_issue.data;

endmodule
`default_nettype wire

// File: tb/tb_mem_req_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_req_queue
// Brief    : Self-checking bench for mem_req_queue with a mem_system stub and
//            an in-order scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_req_queue;
    import mem_req_pkg::*;

    localparam int DEPTH = 2;
`ifdef MEMQ_ALIGN_CHK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wr = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic        rsp_hit;
    logic        rsp_err;
    logic [15:0] mem_addr;
    logic [15:0] mem_data_in;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_data_out = '0;
    logic        mem_done = 1'b0;
    logic        mem_hit = 1'b0;
    logic        mem_err = 1'b0;

    always #5 clk = ~clk;

    mem_req_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_hit(rsp_hit), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .mem_data_out(mem_data_out), .mem_done(mem_done),
        .mem_hit(mem_hit), .mem_err(mem_err)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // The stub's hit/err are pure functions of the address so the model can predict them.
    function automatic logic hit_of(input logic [15:0] a);
        return a[4];
    endfunction
    function automatic logic err_of(input logic [15:0] a);
        return a[15:12] == 4'hE;
    endfunction

    mem_req_t    tx_q[$];
    mem_req_t    iss_q[$];
    mem_req_t    rsp_q[$];
    int          lat_q[$];
    logic [15:0] rsp_log[$];
    logic [15:0] stub_mem [logic [15:0]];
    logic [15:0] model_mem [logic [15:0]];

    int n_acc = 0, n_rsp = 0, n_issue = 0;
    int acc_cyc = 0, last_iss_cyc = 0, last_rsp_cyc = 0;
    int rdy_mode = 1;
    bit rand_valid = 1'b0;
    logic [15:0] last_data;
    logic        last_hit, last_err;

    // mem_system stub: latency per request from lat_q, else random 1..30.
    bit       s_busy = 1'b0;
    bit       done_prev = 1'b0;
    int       s_cnt = 0, s_lat = 0;
    mem_req_t s_req;
    always @(negedge clk) begin
        if (rst) begin
            s_busy = 1'b0; done_prev = 1'b0; s_cnt = 0; mem_done = 1'b0;
        end else begin
            mem_done     = 1'b0;
            mem_data_out = 16'($urandom);
            mem_hit      = 1'($urandom);
            mem_err      = 1'($urandom);
            if (done_prev) begin
                done_prev = 1'b0;
                chk("rsp_valid_after_done", rsp_valid, 1);
                chk("strobe_low_after_done", mem_rd | mem_wr, 0);
            end
            if (mem_rd || mem_wr) begin
                chk("one_strobe", mem_rd & mem_wr, 0);
                if (!s_busy) begin
                    mem_req_t e;
                    s_busy = 1'b1; s_cnt = 0; n_issue++; last_iss_cyc = cyc;
                    s_req = '{wr: mem_wr, addr: mem_addr, data: mem_data_in};
                    if (lat_q.size() > 0) s_lat = lat_q.pop_front();
                    else s_lat = int'($urandom_range(1, 30));
                    chk("issue_expected", iss_q.size() > 0, 1);
                    if (iss_q.size() > 0) begin
                        e = iss_q.pop_front();
                        chk("issue_wr", mem_wr, e.wr);
                        chk("issue_addr", mem_addr, e.addr);
                        chk("issue_data", mem_data_in, e.data);
                    end
                end else begin
                    chk("hold_addr", mem_addr, s_req.addr);
                    chk("hold_data", mem_data_in, s_req.data);
                    chk("hold_wr", mem_wr, s_req.wr);
                end
                s_cnt++;
                if (s_cnt >= s_lat) begin
                    mem_done = 1'b1;
                    mem_hit  = hit_of(s_req.addr);
                    mem_err  = err_of(s_req.addr);
                    if (s_req.wr) stub_mem[s_req.addr] = s_req.data;
                    else mem_data_out = stub_mem.exists(s_req.addr) ? stub_mem[s_req.addr] : 16'h0;
                    done_prev = 1'b1;
                    s_busy    = 1'b0;
                end
            end else if (s_busy) begin
                chk("strobe_held_until_done", mem_rd | mem_wr, 1);
                s_busy = 1'b0;
            end
        end
    end

    // Scoreboard: responses in acceptance order, memory modelled as a plain array.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            mem_req_t    r;
            logic [15:0] ed;
            logic        eh, ee;
            n_rsp++;
            last_rsp_cyc = cyc;
            last_data = rsp_data; last_hit = rsp_hit; last_err = rsp_err;
            rsp_log.push_back(rsp_data);
            chk("rsp_expected", rsp_q.size() > 0, 1);
            if (rsp_q.size() > 0) begin
                r = rsp_q.pop_front();
                if (ALIGN_EN && r.addr[0]) begin
                    ed = 16'h0; eh = 1'b0; ee = 1'b1;
                end else begin
                    eh = hit_of(r.addr); ee = err_of(r.addr);
                    if (r.wr) begin
                        ed = 16'h0; model_mem[r.addr] = r.data;
                    end else begin
                        ed = model_mem.exists(r.addr) ? model_mem[r.addr] : 16'h0;
                    end
                end
                chk("rsp_data", rsp_data, ed);
                chk("rsp_hit", rsp_hit, eh);
                chk("rsp_err", rsp_err, ee);
            end
        end
    end

    task automatic drive(input int ncyc);
        bit       acc;
        mem_req_t r;
        for (int i = 0; i < ncyc; i++) begin
            case (rdy_mode)
                0:       rsp_ready = 1'b0;
                1:       rsp_ready = 1'b1;
                default: rsp_ready = 1'($urandom);
            endcase
            if (tx_q.size() > 0 && (!rand_valid || $urandom_range(0, 3) != 0)) begin
                req_valid = 1'b1;
                req_wr = tx_q[0].wr; req_addr = tx_q[0].addr; req_data = tx_q[0].data;
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
            acc = req_valid && req_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                r = tx_q.pop_front();
                rsp_q.push_back(r);
                if (!(ALIGN_EN && r.addr[0])) iss_q.push_back(r);
                n_acc++;
                acc_cyc = cyc;
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic run_until_rsp(input int target, input int bound, input string name);
        int k = 0;
        while (n_rsp < target && k < bound) begin
            drive(1);
            k++;
        end
        chk(name, n_rsp >= target, 1);
    endtask

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [15:0] data;
        int          lat;
        logic [15:0] exp_data;
        bit          exp_hit;
        bit          exp_err;
    } vec_t;

    vec_t        tbl[10];
    logic [15:0] pool[8];

    initial begin
        int base_acc, base_iss, base_rsp;

        tbl[0] = '{1'b1, 16'h0040, 16'h1234, 2,  16'h0000, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 16'h0040, 16'h0000, 4,  16'h1234, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 16'h0010, 16'hAAAA, 1,  16'h0000, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 16'h0020, 16'h5555, 1,  16'h0000, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 16'h0030, 16'h0F0F, 1,  16'h0000, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 16'h0010, 16'h0000, 1,  16'hAAAA, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 16'h0020, 16'h0000, 20, 16'h5555, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 16'h0030, 16'h0000, 4,  16'h0F0F, 1'b1, 1'b0};
        tbl[8] = '{1'b1, 16'hE010, 16'hBEEF, 3,  16'h0000, 1'b1, 1'b1};
        tbl[9] = '{1'b0, 16'hE010, 16'h0000, 2,  16'hBEEF, 1'b1, 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_hit", rsp_hit, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_strobes", {mem_rd, mem_wr}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_data_in", mem_data_in, 0);
        rst = 1'b0;

        // Table: one request at a time, fixed stub latency
        rdy_mode = 1;
        for (int i = 0; i < 10; i++) begin
            lat_q.push_back(tbl[i].lat);
            tx_q.push_back('{wr: tbl[i].wr, addr: tbl[i].addr, data: tbl[i].data});
            run_until_rsp(n_rsp + 1, 200, "tbl_timeout");
            chk("tbl_data", last_data, tbl[i].exp_data);
            chk("tbl_hit", last_hit, tbl[i].exp_hit);
            chk("tbl_err", last_err, tbl[i].exp_err);
            chk("tbl_issue_latency", last_iss_cyc - acc_cyc, 1);
            chk("tbl_rsp_latency", last_rsp_cyc - last_iss_cyc, tbl[i].lat);
        end

        // Ordering with latencies 1, 20, 4
        rsp_log.delete();
        lat_q = '{1, 20, 4};
        tx_q.push_back('{wr: 1'b0, addr: 16'h0010, data: 16'h0});
        tx_q.push_back('{wr: 1'b0, addr: 16'h0020, data: 16'h0});
        tx_q.push_back('{wr: 1'b0, addr: 16'h0030, data: 16'h0});
        run_until_rsp(n_rsp + 3, 300, "order_timeout");
        chk("order_0", rsp_log[0], 16'hAAAA);
        chk("order_1", rsp_log[1], 16'h5555);
        chk("order_2", rsp_log[2], 16'h0F0F);

        // Back-pressure: response held, DEPTH=2 queue fills behind one in flight
        base_acc = n_acc; base_iss = n_issue; base_rsp = n_rsp;
        rdy_mode = 0;
        lat_q = '{2, 2, 2, 2};
        tx_q.push_back('{wr: 1'b0, addr: 16'h0010, data: 16'h0});
        tx_q.push_back('{wr: 1'b0, addr: 16'h0020, data: 16'h0});
        tx_q.push_back('{wr: 1'b0, addr: 16'h0030, data: 16'h0});
        tx_q.push_back('{wr: 1'b0, addr: 16'h0040, data: 16'h0});
        drive(30);
        chk("bp_accepted", n_acc - base_acc, 3);
        chk("bp_issued", n_issue - base_iss, 1);
        chk("bp_req_ready", req_ready, 0);
        chk("bp_rsp_valid", rsp_valid, 1);
        rdy_mode = 1;
        run_until_rsp(base_rsp + 4, 300, "bp_drain_timeout");
        chk("bp_issued_all", n_issue - base_iss, 4);

        // Reset while BUSY
        lat_q = '{50, 2, 2};
        base_iss = n_issue;
        tx_q.push_back('{wr: 1'b0, addr: 16'h0040, data: 16'h0});
        tx_q.push_back('{wr: 1'b0, addr: 16'h0010, data: 16'h0});
        tx_q.push_back('{wr: 1'b1, addr: 16'h0020, data: 16'h7777});
        for (int k = 0; k < 10 && n_issue == base_iss; k++) drive(1);
        chk("rb_started", n_issue - base_iss, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("rb_strobes_async", {mem_rd, mem_wr}, 0);
        chk("rb_rsp_valid", rsp_valid, 0);
        chk("rb_req_ready", req_ready, 1);
        tx_q.delete(); iss_q.delete(); rsp_q.delete(); lat_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        base_iss = n_issue; base_rsp = n_rsp;
        drive(10);
        chk("rb_no_issue", n_issue - base_iss, 0);
        chk("rb_no_rsp", n_rsp - base_rsp, 0);
        chk("rb_req_ready_after", req_ready, 1);

        // Misaligned load
        base_iss = n_issue;
        if (!ALIGN_EN) lat_q.push_back(3);
        tx_q.push_back('{wr: 1'b0, addr: 16'h0041, data: 16'h0});
        run_until_rsp(n_rsp + 1, 100, "mis_timeout");
`ifdef MEMQ_ALIGN_CHK_EN
        chk("mis_no_issue", n_issue - base_iss, 0);
        chk("mis_err", last_err, 1);
        chk("mis_data", last_data, 0);
        chk("mis_rsp_latency", last_rsp_cyc - acc_cyc, 1);
`else
        chk("mis_issued", n_issue - base_iss, 1);
        chk("mis_err", last_err, 0);
        chk("mis_rsp_latency", last_rsp_cyc - last_iss_cyc, 3);
`endif

        // Random traffic
        pool[0] = 16'h0010; pool[1] = 16'h0020; pool[2] = 16'h0030; pool[3] = 16'h0040;
        pool[4] = 16'hE010; pool[5] = 16'h0052; pool[6] = 16'h0041; pool[7] = 16'h1000;
        rdy_mode = 2;
        rand_valid = 1'b1;
        base_rsp = n_rsp;
        for (int i = 0; i < 80; i++) begin
            mem_req_t r;
            r.wr   = 1'($urandom);
            r.addr = pool[$urandom_range(0, 7)];
            r.data = 16'($urandom);
            tx_q.push_back(r);
        end
        run_until_rsp(base_rsp + 80, 8000, "rand_timeout");
        rdy_mode = 1;
        rand_valid = 1'b0;
        drive(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
